vend_status_uart_tx: RTL and testbench

//  UART transmitter for the vending machine's return path. The vending FSM hands

---
 rtl/vend_status_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_vend_status_uart_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_status_uart_tx.sv
// vend_status_uart_tx: formats vending status reports as ASCII lines and sends them over a UART TxD.
// Optional macro VEND_TX_PARITY_EN selects 8E1 framing; otherwise 8N1.
`default_nettype none

module vend_status_uart_tx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       report_valid_i,
  input  logic       report_kind_i,
  input  logic [4:0] report_value_i,
  output logic       report_ready_o,
  output logic       txd_o,
  output logic       busy_o,
  output logic       msg_done_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef VEND_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_NEXT   = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [2:0]       byte_idx_q;
  logic             kind_q;
  logic [4:0]       value_q;
  logic             txd_q;
  logic             done_q;

  logic [1:0] tens;
  logic [4:0] tens_x10;
  logic [4:0] ones;
  logic [7:0] tx_byte;
  logic [2:0] last_idx;
  logic [2:0] next_bit;
  logic       bit_end;

  // Digit split by comparison: the value never exceeds 31, so no divider is needed.
  always_comb begin
    tens     = 2'd0;
    tens_x10 = 5'd0;
    if (value_q >= 5'd20) begin
      tens     = 2'd2;
      tens_x10 = 5'd20;
    end else if (value_q >= 5'd10) begin
      tens     = 2'd1;
      tens_x10 = 5'd10;
    end
    ones = value_q - tens_x10;
  end

  always_comb begin
    tx_byte = 8'h0A;
    if (!kind_q) begin
      case (byte_idx_q)
        3'd0:    tx_byte = 8'h54;
        3'd1:    tx_byte = (value_q > 5'd29) ? 8'h3F : (8'h30 + {6'd0, tens});
        3'd2:    tx_byte = (value_q > 5'd29) ? 8'h3F : (8'h30 + {3'd0, ones});
        3'd3:    tx_byte = 8'h0D;
        default: tx_byte = 8'h0A;
      endcase
    end else begin
      case (byte_idx_q)
        3'd0:    tx_byte = 8'h56;
        3'd1:    tx_byte = (value_q > 5'd9) ? 8'h3F : (8'h30 + {3'd0, value_q});
        3'd2:    tx_byte = 8'h0D;
        default: tx_byte = 8'h0A;
      endcase
    end
  end

  assign last_idx = kind_q ? 3'd3 : 3'd4;
  assign next_bit = bit_idx_q + 3'd1;
  assign bit_end  = (cnt_q == CNT_LAST);

  // txd is registered and loaded on each state transition with the level of the bit being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      kind_q     <= 1'b0;
      value_q    <= 5'd0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (report_valid_i) begin
            kind_q     <= report_kind_i;
            value_q    <= report_value_i;
            byte_idx_q <= 3'd0;
            cnt_q      <= '0;
            txd_q      <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            txd_q     <= tx_byte[0];
            state_q   <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef VEND_TX_PARITY_EN
              txd_q   <= ^tx_byte;
              state_q <= S_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= next_bit;
              txd_q     <= tx_byte[next_bit];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef VEND_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= S_NEXT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (byte_idx_q == last_idx) begin
            byte_idx_q <= 3'd0;
            done_q     <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            byte_idx_q <= byte_idx_q + 3'd1;
            txd_q      <= 1'b0;
            state_q    <= S_START;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign report_ready_o = (state_q == S_IDLE);
  assign busy_o         = ~report_ready_o;
  assign txd_o          = txd_q;
  assign msg_done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_status_uart_tx.sv
// Bench for vend_status_uart_tx: vector table, corner sequences and random reports checked
// cycle by cycle against a message/waveform model (10 clk per bit).
`default_nettype none

module tb_vend_status_uart_tx;

  localparam int CPB = 10;
`ifdef VEND_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int L = FBITS * CPB + 1;
  localparam logic [3:0] IDLE_ST = 4'b1010;  // {txd, busy, ready, done}

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic       kind;
  logic [4:0] value;
  logic       ready, txd, busy, done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       kind;
    logic [4:0] value;
    int         n;
    logic [39:0] bytes;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  vend_status_uart_tx #(.CLK_HZ(1000), .BAUD(100)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .report_valid_i (valid),
    .report_kind_i  (kind),
    .report_value_i (value),
    .report_ready_o (ready),
    .txd_o          (txd),
    .busy_o         (busy),
    .msg_done_o     (done)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (txd,busy,ready,done) at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] model_msg(input logic k, input int v, output int n);
    logic [39:0] m;
    m = '0;
    if (!k) begin
      n = 5;
      m[7:0] = 8'h54;
      if (v > 29) begin
        m[15:8]  = 8'h3F;
        m[23:16] = 8'h3F;
      end else begin
        m[15:8]  = 8'(48 + v / 10);
        m[23:16] = 8'(48 + v % 10);
      end
      m[31:24] = 8'h0D;
      m[39:32] = 8'h0A;
    end else begin
      n = 4;
      m[7:0]   = 8'h56;
      m[15:8]  = (v > 9) ? 8'h3F : 8'(48 + v);
      m[23:16] = 8'h0D;
      m[31:24] = 8'h0A;
    end
    return m;
  endfunction

  // Line level c clocks after the accepting edge.
  function automatic logic exp_txd(input logic [39:0] msg, input int c);
    int b, r, p;
    logic [7:0] d;
    b = c / L;
    r = c % L;
    if (r == FBITS * CPB) return 1'b1;
    p = r / CPB;
    d = msg[8*b +: 8];
    if (p == 0) return 1'b0;
    if (p <= 8) return d[p-1];
`ifdef VEND_TX_PARITY_EN
    if (p == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic send(input logic k, input logic [4:0] v, input bit hold);
    int t;
    t = 0;
    while (!ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      check("ready_timeout", {3'b0, ready}, 4'b0001);
    end
    valid = 1'b1;
    kind  = k;
    value = v;
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic check_msg(input logic [39:0] msg, input int n, input int poke_at, input string tag);
    for (int c = 0; c < n * L; c++) begin
      @(negedge clk);
      check({tag, "_frame"}, {txd, busy, ready, done}, {exp_txd(msg, c), 1'b1, 1'b0, 1'b0});
      if (poke_at >= 0 && c == poke_at) begin
        valid = 1'b1;
        kind  = ~kind;
        value = 5'd3;
      end else if (poke_at >= 0 && c == poke_at + 1) begin
        valid = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_done"}, {txd, busy, ready, done}, 4'b1011);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] m;
    int n;
    logic k;
    logic [4:0] v;

    tbl[0] = '{1'b1, 5'd7,  4, 40'h000A0D3756};
    tbl[1] = '{1'b0, 5'd23, 5, 40'h0A0D333254};
    tbl[2] = '{1'b0, 5'd31, 5, 40'h0A0D3F3F54};
    tbl[3] = '{1'b0, 5'd0,  5, 40'h0A0D303054};
    tbl[4] = '{1'b0, 5'd29, 5, 40'h0A0D393254};
    tbl[5] = '{1'b0, 5'd10, 5, 40'h0A0D303154};
    tbl[6] = '{1'b0, 5'd30, 5, 40'h0A0D3F3F54};
    tbl[7] = '{1'b1, 5'd9,  4, 40'h000A0D3956};
    tbl[8] = '{1'b1, 5'd10, 4, 40'h000A0D3F56};
    tbl[9] = '{1'b1, 5'd0,  4, 40'h000A0D3056};

    rst_n = 1'b0;
    valid = 1'b0;
    kind  = 1'b0;
    value = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_state", {txd, busy, ready, done}, IDLE_ST);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_after_reset", {txd, busy, ready, done}, IDLE_ST);
    end

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].kind, tbl[i].value, 1'b0);
      check_msg(tbl[i].bytes, tbl[i].n, -1, "table");
      @(negedge clk);
      check("table_done_clears", {txd, busy, ready, done}, IDLE_ST);
    end

    // A one-cycle request while busy must be dropped.
    m = model_msg(1'b1, 7, n);
    send(1'b1, 5'd7, 1'b0);
    check_msg(m, n, 150, "busy_poke");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("no_extra_msg", {txd, busy, ready, done}, IDLE_ST);
    end

    // Request held through msg_done: second message begins on the very next edge.
    m = model_msg(1'b0, 23, n);
    send(1'b0, 5'd23, 1'b1);
    check_msg(m, n, -1, "hold_first");
    @(posedge clk);
    #1;
    valid = 1'b0;
    check_msg(m, n, -1, "hold_second");
    @(negedge clk);
    check("hold_idle", {txd, busy, ready, done}, IDLE_ST);

    // Asynchronous reset in the middle of byte 2 (txd low in data bit 2).
    m = model_msg(1'b0, 23, n);
    send(1'b0, 5'd23, 1'b0);
    repeat (2 * L + 35) @(negedge clk);
    check("pre_reset", {txd, busy, ready, done}, {exp_txd(m, 2 * L + 34), 1'b1, 1'b0, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {txd, busy, ready, done}, IDLE_ST);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {txd, busy, ready, done}, IDLE_ST);
    m = model_msg(1'b1, 5, n);
    send(1'b1, 5'd5, 1'b0);
    check_msg(m, n, -1, "post_reset_msg");

    for (int i = 0; i < 25; i++) begin
      k = 1'($urandom_range(0, 1));
      v = 5'($urandom_range(0, 31));
      m = model_msg(k, int'(v), n);
      @(negedge clk);
      check("rand_idle", {txd, busy, ready, done}, IDLE_ST);
      send(k, v, 1'b0);
      check_msg(m, n, -1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
